// File: rtl/mem_ctrl.sv
// Byte-wide RAM port arbiter for the RV32I core: serialises IF fetches and MEM
// loads/stores, assembles bytes little-endian and raises per-stage stall requests.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        b_flag_i,
    output logic [31:0] if_inst,
    output logic        if_done,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_addr,
    output logic        ram_wr,
    output logic        stall_req_if,
    output logic        stall_req_mem
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic [2:0]  r_n;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic [31:0] r_if_inst;
    logic [31:0] r_mem_rdata;
    logic        r_if_done;
    logic        r_mem_done;

    logic        w_mem_go;
    logic        w_if_go;
    logic        w_if_fin;
    logic        w_mem_fin;
    logic [2:0]  w_len_n;
    logic [1:0]  w_lane;
    logic [31:0] w_asm;
    logic [31:0] w_ram_addr;
    logic [7:0]  w_ram_dout;
    logic        w_ram_wr;

    // A request is taken only while its stall is raised, so a stage holding its
    // request through the done cycle is not serviced twice.
    assign w_mem_go = mem_req & ~r_mem_done;
    assign w_if_go  = if_req & ~r_if_done & ~b_flag_i;
    assign w_len_n  = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;
    assign w_lane   = r_cnt[1:0] - 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      r_state <= S_IDLE;
        else if (rdy) r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_next     = r_state;
        w_if_fin   = 1'b0;
        w_mem_fin  = 1'b0;
        w_ram_addr = 32'd0;
        w_ram_wr   = 1'b0;
        w_ram_dout = 8'd0;
        w_asm      = r_buf;
        if (r_cnt != 3'd0) w_asm[{w_lane, 3'b000} +: 8] = ram_din;

        case (r_state)
            S_IDLE: begin
                if (w_mem_go)     w_next = mem_we ? S_STORE : S_LOAD;
                else if (w_if_go) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_ram_addr = r_base + {29'd0, r_cnt};
                if (b_flag_i) begin
                    w_next = S_IDLE;
                end else if (r_cnt == r_n) begin
                    w_next   = S_IDLE;
                    w_if_fin = 1'b1;
                end
            end
            S_LOAD: begin
                w_ram_addr = r_base + {29'd0, r_cnt};
                if (r_cnt == r_n) begin
                    w_next    = S_IDLE;
                    w_mem_fin = 1'b1;
                end
            end
            S_STORE: begin
                w_ram_addr = r_base + {29'd0, r_cnt};
                w_ram_wr   = 1'b1;
                w_ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                if (r_cnt == r_n - 3'd1) begin
                    w_next    = S_IDLE;
                    w_mem_fin = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 3'd0;
            r_n         <= 3'd0;
            r_base      <= 32'd0;
            r_wdata     <= 32'd0;
            r_buf       <= 32'd0;
            r_if_inst   <= 32'd0;
            r_mem_rdata <= 32'd0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
        end else if (rdy) begin
            r_if_done  <= w_if_fin;
            r_mem_done <= w_mem_fin;
            if (r_state == S_IDLE) begin
                r_cnt <= 3'd0;
                r_buf <= 32'd0;
                if (w_mem_go) begin
                    r_base  <= mem_addr;
                    r_n     <= w_len_n;
                    r_wdata <= mem_wdata;
                end else if (w_if_go) begin
                    r_base <= if_addr;
                    r_n    <= 3'd4;
                end
            end else begin
                r_cnt <= r_cnt + 3'd1;
                if (r_state != S_STORE) r_buf <= w_asm;
            end
            if (w_if_fin)                         r_if_inst   <= w_asm;
            if (w_mem_fin && r_state == S_LOAD)   r_mem_rdata <= w_asm;
        end
    end

    assign if_inst       = r_if_inst;
    assign if_done       = r_if_done;
    assign mem_rdata     = r_mem_rdata;
    assign mem_done      = r_mem_done;
    assign ram_addr      = w_ram_addr;
    assign ram_wr        = w_ram_wr;
    assign ram_dout      = w_ram_dout;
    assign stall_req_mem = w_mem_go;
    assign stall_req_if  = w_if_go;
endmodule
